// File: rtl/lcd_pkg.sv
// Shared LCD command bytes, top-level state encoding and a small elaboration helper.
package lcd_pkg;

    localparam logic [7:0] LCD_FUNC_4BIT_2LINE = 8'h28;
    localparam logic [7:0] LCD_DISP_ON         = 8'h0C;
    localparam logic [7:0] LCD_ENTRY_INC       = 8'h06;
    localparam logic [7:0] LCD_CLEAR           = 8'h01;
    localparam logic [7:0] LCD_ROW_A_ADDR      = 8'h80;
    localparam logic [7:0] LCD_ROW_B_ADDR      = 8'hC0;
    localparam logic [3:0] LCD_WAKE_NIBBLE     = 4'h3;
    localparam logic [3:0] LCD_4BIT_NIBBLE     = 4'h2;

    typedef enum logic [2:0] {
        S_PWR,
        S_WAKE,
        S_CFG,
        S_LATCH,
        S_ADDR,
        S_DATA
    } lcd_state_t;

    function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    cfg_byte = LCD_FUNC_4BIT_2LINE;
            2'd1:    cfg_byte = LCD_DISP_ON;
            2'd2:    cfg_byte = LCD_ENTRY_INC;
            default: cfg_byte = LCD_CLEAR;
        endcase
    endfunction

    function automatic int max2(input int a, input int b);
        max2 = (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// One LCD nibble: 1 setup cycle, E high for E_PULSE_TICKS, then wait_ticks_i low; start_i always wins.
// done_o fires one cycle before the wait expires (wait_ticks_i >= 2) so a registered requester lands back-to-back.
module lcd_nibble_tx #(
    parameter int E_PULSE_TICKS = 25,
    parameter int TW            = 22
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_i,
    input  logic [3:0]    nibble_i,
    input  logic          rs_i,
    input  logic [TW-1:0] wait_ticks_i,
    output logic          e_o,
    output logic          rs_o,
    output logic [3:0]    d_o,
    output logic          done_o
);

    typedef enum logic [1:0] {TX_IDLE, TX_SETUP, TX_PULSE, TX_WAIT} tx_state_t;

    localparam logic [TW-1:0] PULSE_LAST = TW'(E_PULSE_TICKS - 1);

    tx_state_t     state_q;
    logic [TW-1:0] cnt_q;
    logic [TW-1:0] wait_q;

    assign done_o = (state_q == TX_WAIT) && (cnt_q == wait_q - TW'(2));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            wait_q  <= '0;
            e_o     <= 1'b0;
            rs_o    <= 1'b0;
            d_o     <= 4'h0;
        end else if (start_i) begin
            state_q <= TX_SETUP;
            cnt_q   <= '0;
            wait_q  <= wait_ticks_i;
            e_o     <= 1'b0;
            rs_o    <= rs_i;
            d_o     <= nibble_i;
        end else begin
            case (state_q)
                TX_SETUP: begin
                    e_o     <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= TX_PULSE;
                end
                TX_PULSE: begin
                    if (cnt_q == PULSE_LAST) begin
                        e_o     <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= TX_WAIT;
                    end else begin
                        cnt_q <= cnt_q + TW'(1);
                    end
                end
                TX_WAIT: begin
                    if (cnt_q == wait_q - TW'(1)) begin
                        state_q <= TX_IDLE;
                    end else begin
                        cnt_q <= cnt_q + TW'(1);
                    end
                end
                default: state_q <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lcd_row_driver.sv
// Mirrors two 16-char rows onto an HD44780 16x2 LCD in 4-bit mode, forever, after power-up init.
// No upstream handshake: rows are snapshotted once per frame, so a frame never tears.
module lcd_row_driver #(
    parameter int E_PULSE_TICKS          = 25,
    parameter int NIBBLE_GAP_TICKS       = 100,
    parameter int CMD_WAIT_TICKS         = 5000,
    parameter int CLEAR_WAIT_TICKS       = 200000,
    parameter int INIT_NIBBLE_WAIT_TICKS = 500000,
    parameter int POWER_WAIT_TICKS       = 2000000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] row_A,
    input  logic [127:0] row_B,
    output logic         LCD_E,
    output logic         LCD_RS,
    output logic         LCD_RW,
    output logic [3:0]   LCD_D,
    output logic         frame_done
);

    import lcd_pkg::*;

    localparam int MAX_TICKS = max2(max2(max2(E_PULSE_TICKS, NIBBLE_GAP_TICKS),
                                         max2(CMD_WAIT_TICKS, CLEAR_WAIT_TICKS)),
                                    max2(INIT_NIBBLE_WAIT_TICKS, POWER_WAIT_TICKS));
    localparam int TW = $clog2(MAX_TICKS) + 1;

    localparam logic [TW-1:0] GAP_W  = TW'(NIBBLE_GAP_TICKS);
    localparam logic [TW-1:0] CMD_W  = TW'(CMD_WAIT_TICKS);
    localparam logic [TW-1:0] CLR_W  = TW'(CLEAR_WAIT_TICKS);
    localparam logic [TW-1:0] INIT_W = TW'(INIT_NIBBLE_WAIT_TICKS);
    // start is registered and the nibble TX loads one edge later, so launch two counts early.
    localparam logic [TW-1:0] PWR_LAST = TW'(POWER_WAIT_TICKS - 2);

    lcd_state_t    state_q;
    logic [TW-1:0] pwr_cnt_q;
    logic [TW-1:0] wait_q;
    logic [1:0]    step_q;
    logic [3:0]    idx_q;
    logic [3:0]    nib_q;
    logic          lo_q;
    logic          row_b_q;
    logic          start_q;
    logic          rs_q;
    logic          frame_done_q;
    logic [255:0]  shadow_q;
    logic          tx_done;
    logic [7:0]    cur_char;
    logic [7:0]    next_char;
    logic [7:0]    cfg_cur;
    logic [7:0]    cfg_next;

    // shadow_q shifts left one char per sent byte, so the current char is always the top byte.
    assign cur_char   = shadow_q[255:248];
    assign next_char  = shadow_q[247:240];
    assign cfg_cur    = cfg_byte(step_q);
    assign cfg_next   = cfg_byte(step_q + 2'd1);
    assign LCD_RW     = 1'b0;
    assign frame_done = frame_done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_PWR;
            pwr_cnt_q    <= '0;
            wait_q       <= '0;
            step_q       <= '0;
            idx_q        <= '0;
            nib_q        <= '0;
            lo_q         <= 1'b0;
            row_b_q      <= 1'b0;
            start_q      <= 1'b0;
            rs_q         <= 1'b0;
            frame_done_q <= 1'b0;
            shadow_q     <= '0;
        end else begin
            start_q      <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                S_PWR: begin
                    if (pwr_cnt_q == PWR_LAST) begin
                        state_q <= S_WAKE;
                        step_q  <= '0;
                        start_q <= 1'b1;
                        nib_q   <= LCD_WAKE_NIBBLE;
                        rs_q    <= 1'b0;
                        wait_q  <= INIT_W;
                    end else begin
                        pwr_cnt_q <= pwr_cnt_q + TW'(1);
                    end
                end
                S_WAKE: if (tx_done) begin
                    if (step_q == 2'd3) begin
                        state_q <= S_CFG;
                        step_q  <= '0;
                        lo_q    <= 1'b0;
                        nib_q   <= LCD_FUNC_4BIT_2LINE[7:4];
                        wait_q  <= GAP_W;
                    end else begin
                        step_q  <= step_q + 2'd1;
                        nib_q   <= (step_q == 2'd2) ? LCD_4BIT_NIBBLE : LCD_WAKE_NIBBLE;
                        wait_q  <= INIT_W;
                    end
                    start_q <= 1'b1;
                    rs_q    <= 1'b0;
                end
                S_CFG: if (tx_done) begin
                    if (!lo_q) begin
                        lo_q    <= 1'b1;
                        start_q <= 1'b1;
                        nib_q   <= cfg_cur[3:0];
                        rs_q    <= 1'b0;
                        wait_q  <= (step_q == 2'd3) ? CLR_W : CMD_W;
                    end else begin
                        lo_q <= 1'b0;
                        if (step_q == 2'd3) begin
                            state_q <= S_LATCH;
                        end else begin
                            step_q  <= step_q + 2'd1;
                            start_q <= 1'b1;
                            nib_q   <= cfg_next[7:4];
                            rs_q    <= 1'b0;
                            wait_q  <= GAP_W;
                        end
                    end
                end
                S_LATCH: begin
                    shadow_q <= {row_A, row_B};
                    idx_q    <= '0;
                    row_b_q  <= 1'b0;
                    lo_q     <= 1'b0;
                    state_q  <= S_ADDR;
                    start_q  <= 1'b1;
                    nib_q    <= LCD_ROW_A_ADDR[7:4];
                    rs_q     <= 1'b0;
                    wait_q   <= GAP_W;
                end
                S_ADDR: if (tx_done) begin
                    start_q <= 1'b1;
                    if (!lo_q) begin
                        lo_q   <= 1'b1;
                        nib_q  <= row_b_q ? LCD_ROW_B_ADDR[3:0] : LCD_ROW_A_ADDR[3:0];
                        rs_q   <= 1'b0;
                        wait_q <= CMD_W;
                    end else begin
                        lo_q    <= 1'b0;
                        state_q <= S_DATA;
                        nib_q   <= cur_char[7:4];
                        rs_q    <= 1'b1;
                        wait_q  <= GAP_W;
                    end
                end
                S_DATA: if (tx_done) begin
                    if (!lo_q) begin
                        lo_q    <= 1'b1;
                        start_q <= 1'b1;
                        nib_q   <= cur_char[3:0];
                        rs_q    <= 1'b1;
                        wait_q  <= CMD_W;
                    end else begin
                        lo_q     <= 1'b0;
                        shadow_q <= {shadow_q[247:0], 8'h00};
                        idx_q    <= idx_q + 4'd1;
                        if (idx_q == 4'd15 && row_b_q) begin
                            frame_done_q <= 1'b1;
                            state_q      <= S_LATCH;
                        end else if (idx_q == 4'd15) begin
                            row_b_q <= 1'b1;
                            state_q <= S_ADDR;
                            start_q <= 1'b1;
                            nib_q   <= LCD_ROW_B_ADDR[7:4];
                            rs_q    <= 1'b0;
                            wait_q  <= GAP_W;
                        end else begin
                            start_q <= 1'b1;
                            nib_q   <= next_char[7:4];
                            rs_q    <= 1'b1;
                            wait_q  <= GAP_W;
                        end
                    end
                end
                default: state_q <= S_PWR;
            endcase
        end
    end

    lcd_nibble_tx #(
        .E_PULSE_TICKS (E_PULSE_TICKS),
        .TW            (TW)
    ) u_tx (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_q),
        .nibble_i     (nib_q),
        .rs_i         (rs_q),
        .wait_ticks_i (wait_q),
        .e_o          (LCD_E),
        .rs_o         (LCD_RS),
        .d_o          (LCD_D),
        .done_o       (tx_done)
    );

endmodule

// File: tb/tb_lcd_row_driver.sv
// Randomised-row bench: decodes the LCD bus into nibbles and checks them against a frame-level model.
module tb_lcd_row_driver;

    localparam int NIB_GAP   = 3;
    localparam int INIT_LEN  = 12;
    localparam int FRAME_LEN = 68;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] row_A;
    logic [127:0] row_B;
    logic         LCD_E;
    logic         LCD_RS;
    logic         LCD_RW;
    logic [3:0]   LCD_D;
    logic         frame_done;

    int vectors     = 0;
    int miscompares = 0;

    logic [4:0] got_q[$];
    logic [4:0] exp_q[$];
    int         fd_q[$];

    always #5 clk = ~clk;

    lcd_row_driver #(
        .E_PULSE_TICKS          (2),
        .NIBBLE_GAP_TICKS       (NIB_GAP),
        .CMD_WAIT_TICKS         (5),
        .CLEAR_WAIT_TICKS       (8),
        .INIT_NIBBLE_WAIT_TICKS (6),
        .POWER_WAIT_TICKS       (10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .row_A      (row_A),
        .row_B      (row_B),
        .LCD_E      (LCD_E),
        .LCD_RS     (LCD_RS),
        .LCD_RW     (LCD_RW),
        .LCD_D      (LCD_D),
        .frame_done (frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus monitor: one record per E falling edge, plus pulse-width / setup / hold checks.
    logic [4:0] prev_bus, rise_bus, cur;
    logic       prev_e, prev_fd, seen_rise;
    int         hi_cnt, lo_cnt, chg_cnt;

    always @(negedge clk) begin
        if (reset) begin
            prev_e = 1'b0; prev_fd = 1'b0; seen_rise = 1'b0;
            hi_cnt = 0; lo_cnt = 0; chg_cnt = 0; prev_bus = 5'h0;
        end else begin
            cur = {LCD_RS, LCD_D};
            if (LCD_E && !prev_e) begin
                chk("setup", 32'(cur), 32'(prev_bus));
                chk("rw", 32'(LCD_RW), 32'(0));
                if (seen_rise) begin
                    chk("gap_changes", 32'(chg_cnt <= 1), 32'(1));
                    chk("gap_min", 32'(lo_cnt >= NIB_GAP + 1), 32'(1));
                    if (got_q.size() == INIT_LEN) chk("clear_gap", 32'(lo_cnt >= 8), 32'(1));
                end
                rise_bus = cur; hi_cnt = 1; seen_rise = 1'b1;
            end else if (LCD_E) begin
                hi_cnt++;
                chk("hold_hi", 32'(cur), 32'(rise_bus));
            end else if (prev_e) begin
                chk("e_width", 32'(hi_cnt), 32'(2));
                chk("hold_fall", 32'(cur), 32'(rise_bus));
                got_q.push_back(cur);
                lo_cnt = 1; chg_cnt = 0;
            end else begin
                lo_cnt++;
                if (cur != prev_bus) chg_cnt++;
            end
            if (frame_done) begin
                chk("fd_pulse", 32'(prev_fd), 32'(0));
                fd_q.push_back(got_q.size());
            end
            prev_fd  = frame_done;
            prev_e   = LCD_E;
            prev_bus = cur;
        end
    end

    function automatic logic [127:0] rand_row();
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[127-8*k -: 8] = 8'($urandom_range(32, 126));
        return r;
    endfunction

    task automatic push_byte(input logic rs, input logic [7:0] b);
        exp_q.push_back({rs, b[7:4]});
        exp_q.push_back({rs, b[3:0]});
    endtask

    task automatic push_init();
        exp_q.push_back(5'h03); exp_q.push_back(5'h03);
        exp_q.push_back(5'h03); exp_q.push_back(5'h02);
        push_byte(1'b0, 8'h28); push_byte(1'b0, 8'h0C);
        push_byte(1'b0, 8'h06); push_byte(1'b0, 8'h01);
    endtask

    task automatic push_frame(input logic [127:0] a, input logic [127:0] b);
        push_byte(1'b0, 8'h80);
        for (int k = 0; k < 16; k++) push_byte(1'b1, a[127-8*k -: 8]);
        push_byte(1'b0, 8'hC0);
        for (int k = 0; k < 16; k++) push_byte(1'b1, b[127-8*k -: 8]);
    endtask

    task automatic wait_nibbles(input int n, input string tag);
        int t = 0;
        while (got_q.size() < n && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk(tag, 32'(got_q.size() >= n), 32'(1));
    endtask

    task automatic expect_first_rise(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (LCD_E !== 1'b1 && n < 100);
        chk(tag, 32'(n), 32'(11));
        chk({tag, "_d"}, 32'(LCD_D), 32'(3));
        chk({tag, "_rs"}, 32'(LCD_RS), 32'(0));
    endtask

    task automatic check_frames(input int n);
        chk("fd_count", 32'(fd_q.size()), 32'(n));
        for (int j = 0; j < fd_q.size() && j < n; j++)
            chk($sformatf("fd_pos%0d", j), 32'(fd_q[j]), 32'(INIT_LEN + FRAME_LEN * (j + 1)));
    endtask

    task automatic compare_stream(input int min_len);
        chk("stream_len", 32'(got_q.size() >= min_len), 32'(1));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("nib%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    initial begin
        int t;
        reset = 1'b1;
        row_A = "PRESS BTN0      ";
        row_B = "TO START        ";
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_e", 32'(LCD_E), 32'(0));
        chk("rst_rs", 32'(LCD_RS), 32'(0));
        chk("rst_rw", 32'(LCD_RW), 32'(0));
        chk("rst_d", 32'(LCD_D), 32'(0));
        chk("rst_fd", 32'(frame_done), 32'(0));
        reset = 1'b0;
        expect_first_rise("pwr_rise");
        push_init();
        push_frame(row_A, row_B);

        // Rows change only while row B is on the bus, so each change belongs to the next frame.
        for (int k = 0; k < 3; k++) begin
            wait_nibbles(INIT_LEN + FRAME_LEN * k + 40, "wait_rowb");
            if (k == 0) begin
                row_A = "   GAME OVER    ";
            end else begin
                row_A = rand_row();
                row_B = rand_row();
            end
            push_frame(row_A, row_B);
        end

        wait_nibbles(INIT_LEN + FRAME_LEN * 3 + 44, "wait_mid");
        t = 0;
        while (LCD_E !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("mid_e_hi", 32'(LCD_E), 32'(1));
        chk("mid_rs", 32'(LCD_RS), 32'(1));
        reset = 1'b1;
        @(negedge clk);
        chk("rst_drop_e", 32'(LCD_E), 32'(0));
        check_frames(3);
        compare_stream(INIT_LEN + FRAME_LEN * 3 + 44);
        got_q.delete();
        exp_q.delete();
        fd_q.delete();
        row_A = rand_row();
        row_B = rand_row();
        @(negedge clk);
        reset = 1'b0;
        expect_first_rise("rst_pwr_rise");
        push_init();
        push_frame(row_A, row_B);

        t = 0;
        while (fd_q.size() < 1 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check_frames(1);
        compare_stream(INIT_LEN + FRAME_LEN);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lcd_row_driver.md
Name: lcd_row_driver

Overview:
- Downstream display stage for the game top level: takes two 16-character ASCII row buffers and continuously mirrors them onto an HD44780-compatible 16x2 character LCD in 4-bit write-only mode.
- Owns the power-up initialisation sequence and all bus timing.
- Loops a refresh forever, so upstream logic only rewrites its row registers and never handshakes with the LCD.

Parameters:
- E_PULSE_TICKS, 25: clk cycles LCD_E is held high per nibble (250 ns at 100 MHz).
- NIBBLE_GAP_TICKS, 100: cycles with LCD_E low after a nibble before the next nibble of the same byte.
- CMD_WAIT_TICKS, 5000: cycles after a complete byte (command or data) before the next transfer.
- CLEAR_WAIT_TICKS, 200000: cycles after the clear command 0x01, used instead of CMD_WAIT_TICKS.
- INIT_NIBBLE_WAIT_TICKS, 500000: cycles after each of the three bare 0x3 wake-up nibbles.
- POWER_WAIT_TICKS, 2000000: idle cycles after reset before the first nibble.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- row_A  in  128  top line; char k (0 = leftmost) = row_A[127-8k -: 8]
- row_B  in  128  bottom line, same packing as row_A
- LCD_E  out  1  enable strobe
- LCD_RS  out  1  0 = command, 1 = data
- LCD_RW  out  1  tied 0 (write only)
- LCD_D  out  4  data nibble, high nibble sent first
- frame_done  out  1  one-cycle pulse after the last character of row B is sent

Behaviour:
Reset:
- Reset is sampled on clk.
- While asserted: LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_D=0, frame_done=0, all counters cleared, state = S_PWR.
- Reset mid-transfer drops LCD_E on the next edge and restarts the full init sequence. No partial resume.

States:
- S_PWR: count POWER_WAIT_TICKS, then go to S_WAKE.
- S_WAKE: send bare nibble 0x3 three times, then bare nibble 0x2. RS=0. Wait INIT_NIBBLE_WAIT_TICKS after each nibble. Then go to S_CFG.
- S_CFG: send full command bytes 0x28, 0x0C, 0x06, 0x01, in that order. Wait CLEAR_WAIT_TICKS after 0x01. Then go to S_LATCH.
- S_LATCH: one cycle. Copy row_A and row_B into shadow registers. Set char index to 0 and row to A. Go to S_ADDR.
- S_ADDR: send command 0x80 for row A or 0xC0 for row B, then go to S_DATA.
- S_DATA: send the shadow character byte with RS=1, then increment the index.
  - index wraps from 15 on row A: switch to row B and go to S_ADDR.
  - index wraps from 15 on row B: pulse frame_done and go to S_LATCH.

Nibble timing (shared by every transfer):
- Cycle 0: LCD_D and LCD_RS take their new values with LCD_E=0. This gives one cycle of setup.
- Next E_PULSE_TICKS cycles: LCD_E=1.
- LCD_E then returns to 0. LCD_D and LCD_RS hold their values for the whole following wait.
- Wait after the nibble: NIBBLE_GAP_TICKS for the high nibble of a byte; the byte wait for the low nibble; INIT_NIBBLE_WAIT_TICKS for a bare wake-up nibble.

Data handling:
- Upstream changes to row_A or row_B are visible only from the next S_LATCH. A frame never tears mid-frame.
- Characters are passed through unmodified; no ASCII translation.
- All wait counters are sized with $clog2 of the largest tick parameter plus 1. They count 0..N-1 with no wrap beyond.
- Once in S_LATCH, the block never returns to init except on reset.

Decomposition:
- Shared package lcd_pkg holds:
  - command constants: LCD_FUNC_4BIT_2LINE=8'h28, LCD_DISP_ON=8'h0C, LCD_ENTRY_INC=8'h06, LCD_CLEAR=8'h01, LCD_ROW_A_ADDR=8'h80, LCD_ROW_B_ADDR=8'hC0, LCD_WAKE_NIBBLE=4'h3, LCD_4BIT_NIBBLE=4'h2;
  - the state enum typedef.
- One sub-module, lcd_nibble_tx:
  - inputs: start, nibble, rs, wait_ticks;
  - behaviour: drives the E pulse and the post-nibble wait, and raises done for one cycle at the end;
  - the top FSM sequences bytes through it.

Test Plan:
- Sim parameters for all scenarios: E_PULSE_TICKS=2, NIBBLE_GAP_TICKS=3, CMD_WAIT_TICKS=5, CLEAR_WAIT_TICKS=8, INIT_NIBBLE_WAIT_TICKS=6, POWER_WAIT_TICKS=10.
- Reset/power-up: assert reset 3 cycles, then release -> outputs all 0 during reset; first LCD_E rise exactly 11 cycles after release, with LCD_D=3, RS=0.
- Init order: capture all LCD_E falling edges after reset -> nibble stream 3,3,3,2, then 2,8, 0,C, 0,6, 0,1, 8,0, all with RS=0.
- Row content: row_A="PRESS BTN0      ", row_B="TO START        " -> decoded RS=1 bytes are the 16 row A chars, then 0xC0 (RS=0), then the 16 row B chars; frame_done pulses once after the final ' ' byte.
- Latch isolation: change row_A to "   GAME OVER    " while row B is being sent -> current frame shows old row A text; the next frame shows "   GAME OVER    ".
- Timing check: measure every E high width and gap -> E high = 2 cycles; LCD_D/RS stable from 1 cycle before the E rise until the next nibble; gap after the 0x01 low nibble >= 8 cycles.
- Mid-transfer reset: assert reset while LCD_E=1 during row B data -> LCD_E=0 on the next cycle; the sequence restarts with the 10-cycle power wait and the 3,3,3,2 nibbles.
